dsp_27x27s_arbiter: RTL and testbench
=====================================

Name: dsp_27x27s_arbiter

Overview:
Shares one signed 27x27 multiplier pipeline (dsp_27x27s, fixed LATENCY) between NUM_REQ independent requesters. A round-robin arbiter issues at most one product per cycle. Each result is tagged with its requester index and returned through a credit-protected output FIFO, so downstream backpressure never drops an in-flight product. It sits between DSP-consuming client blocks and the hard multiplier.

Parameters:
FAMILY, "Agilex", passed through to dsp_27x27s
LATENCY, 3, multiplier pipeline depth in cycles (>=1), passed through
NUM_REQ, 4, number of requesters (>=1)
AX_WIDTH, 27, signed operand X width
AY_WIDTH, 27, signed operand Y width
RESULT_WIDTH, 54, signed product width (AX_WIDTH+AY_WIDTH)
ID_WIDTH, 2, requester tag width, max(1, clog2(NUM_REQ))

Ports:
clk  in  1  single clock, all logic posedge
aclr_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_ax  in  NUM_REQ*AX_WIDTH  packed signed X operands, requester i at [i*AX_WIDTH +: AX_WIDTH]
req_ay  in  NUM_REQ*AY_WIDTH  packed signed Y operands, same packing
res_valid  out  1  result available
res_ready  in  1  downstream accept
res_id  out  ID_WIDTH  index of requester that issued this product
res_data  out  RESULT_WIDTH  signed product ax*ay

Behaviour:
- Reset (aclr_n=0, async): rr_ptr=0; in-flight valid shift register cleared; FIFO empty; res_valid=0, req_ready=0, res_id=0, res_data=0. Multiplier datapath registers are not reset.
- Transfers: a request transfers when req_valid[i]&&req_ready[i]; a result transfers when res_valid&&res_ready.
- req_ready is combinational from req_valid, rr_ptr and credit. Requesters must not make valid depend on ready. Once asserted, valid and operands are held until transfer.
- Credit: localparam DEPTH = LATENCY+2. can_issue = (inflight + fifo_count) < DEPTH, where inflight = popcount of the LATENCY-stage valid shift register. A pop in the current cycle does not add credit until the next cycle (registered count).
- Arbitration: if can_issue, grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready is one-hot on that grant, otherwise all zero.
- On a grant: rr_ptr <= (grant+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Issue: the granted operands drive dsp_27x27s the same cycle. Valid and id enter a LATENCY-deep shift register aligned with the product.
- Result path: when the shift register output is valid, {id, product} is pushed into the FIFO. Minimum latency from request transfer to res_valid is LATENCY+1 cycles (FIFO registered).
- FIFO is first-word-fall-through. res_id and res_data are valid whenever res_valid=1 and hold stable until transfer.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, order preserved.
- Push never occurs when full; credit guarantees this. Overflow is an assertion failure in simulation.
- Arithmetic: full-precision signed product, no truncation or saturation. It must equal the sign-extended ax * ay.
- NUM_REQ=1: the arbiter degenerates to req_ready = req_valid && can_issue, and res_id is always 0.
- Reset mid-operation: all in-flight and queued results are discarded. No res_valid is asserted until new requests issue after reset release.
- Throughput: with res_ready=1 continuously, one issue per cycle is sustained indefinitely.

Test Plan:
- Single requester 0, valid held high for 20 cycles, random operands, res_ready=1: 20 results with res_id=0, in order, each equal to the reference product. First res_valid appears LATENCY+1 cycles after the first transfer, then there are no bubbles.
- All 4 requesters valid continuously, res_ready=1: grant order 0,1,2,3,0,1,... and res_id follows the same sequence.
- Corner operands: (-1)*(-1) -> 1; (-2^26)*(-2^26) -> 2^52; (2^26-1)*(-2^26) -> -(2^52-2^26); 0*x -> 0.
- Backpressure: res_ready=0 with all requesters valid. Exactly DEPTH=5 requests transfer, then req_ready=0. Raise res_ready: all 5 results emerge in order, none lost, and issue resumes.
- Requester 2 only valid, with rr_ptr=3: 2 is granted immediately and rr_ptr becomes 3. Then 1 and 2 are both valid: 1 is granted before 2 (wrap from 3).
- Assert aclr_n=0 for 1 cycle with 3 products in flight: res_valid=0 and req_ready=0 immediately. After release, no stale results appear and the next request returns correctly.

Source files
------------

// File: rtl/dsp_27x27s_arbiter_if.sv
// Handshake bundle between DSP clients and the shared multiplier arbiter.
// master = client side, slave = arbiter side.
interface dsp_27x27s_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int AX_WIDTH     = 27,
  parameter int AY_WIDTH     = 27,
  parameter int RESULT_WIDTH = AX_WIDTH + AY_WIDTH,
  parameter int ID_WIDTH     = 2
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*AX_WIDTH-1:0] req_ax;
  logic [NUM_REQ*AY_WIDTH-1:0] req_ay;
  logic                        res_valid;
  logic                        res_ready;
  logic [ID_WIDTH-1:0]         res_id;
  logic [RESULT_WIDTH-1:0]     res_data;

  modport master (
    output req_valid, req_ax, req_ay, res_ready,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_ax, req_ay, res_ready,
    output req_ready, res_valid, res_id, res_data
  );
endinterface

// File: rtl/dsp_27x27s_arbiter.sv
// Round-robin sharing of one signed 27x27 multiplier pipeline between
// NUM_REQ clients, with tagged results returned through a credited FIFO.
module dsp_27x27s #(
  parameter string FAMILY       = "Agilex",
  parameter int    LATENCY      = 3,
  parameter int    AX_WIDTH     = 27,
  parameter int    AY_WIDTH     = 27,
  parameter int    RESULT_WIDTH = AX_WIDTH + AY_WIDTH
) (
  input  logic                           clk,
  input  logic signed [AX_WIDTH-1:0]     ax_i,
  input  logic signed [AY_WIDTH-1:0]     ay_i,
  output logic signed [RESULT_WIDTH-1:0] result_o
);
  // Agilex-class blocks absorb an operand register; others pipeline the product only
  localparam bit IN_REG = (LATENCY >= 2) && (FAMILY == "Agilex");

  if (IN_REG) begin : g_inreg
    logic signed [AX_WIDTH-1:0]     ax_q;
    logic signed [AY_WIDTH-1:0]     ay_q;
    logic signed [RESULT_WIDTH-1:0] ax_x;
    logic signed [RESULT_WIDTH-1:0] ay_x;
    logic signed [RESULT_WIDTH-1:0] p_q [LATENCY-1];

    assign ax_x = RESULT_WIDTH'(ax_q);
    assign ay_x = RESULT_WIDTH'(ay_q);

    always_ff @(posedge clk) begin
      ax_q   <= ax_i;
      ay_q   <= ay_i;
      p_q[0] <= ax_x * ay_x;
      for (int i = 1; i < LATENCY - 1; i++) begin
        p_q[i] <= p_q[i-1];
      end
    end

    assign result_o = p_q[LATENCY-2];
  end else begin : g_outreg
    logic signed [RESULT_WIDTH-1:0] ax_x;
    logic signed [RESULT_WIDTH-1:0] ay_x;
    logic signed [RESULT_WIDTH-1:0] p_q [LATENCY];

    assign ax_x = RESULT_WIDTH'(ax_i);
    assign ay_x = RESULT_WIDTH'(ay_i);

    always_ff @(posedge clk) begin
      p_q[0] <= ax_x * ay_x;
      for (int i = 1; i < LATENCY; i++) begin
        p_q[i] <= p_q[i-1];
      end
    end

    assign result_o = p_q[LATENCY-1];
  end
endmodule

module dsp_27x27s_arbiter #(
  parameter string FAMILY       = "Agilex",
  parameter int    LATENCY      = 3,
  parameter int    NUM_REQ      = 4,
  parameter int    AX_WIDTH     = 27,
  parameter int    AY_WIDTH     = 27,
  parameter int    RESULT_WIDTH = AX_WIDTH + AY_WIDTH,
  parameter int    ID_WIDTH     = 2
) (
  input logic                clk,
  input logic                aclr_n,
  dsp_27x27s_arbiter_if.slave bus
);
  localparam int DEPTH = LATENCY + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int EW    = ID_WIDTH + RESULT_WIDTH;

  logic [LATENCY-1:0]      vld_q;
  logic [ID_WIDTH-1:0]     vid_q [LATENCY];
  logic [ID_WIDTH-1:0]     rr_ptr_q;
  logic [ID_WIDTH-1:0]     rr_ptr_d;
  logic [EW-1:0]           mem_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_d;
  logic [CW:0]             inflight;
  logic [CW:0]             used;
  logic                    can_issue;
  logic                    gnt_vld;
  logic [ID_WIDTH-1:0]     gnt_id;
  logic [AX_WIDTH-1:0]     ax_sel;
  logic [AY_WIDTH-1:0]     ay_sel;
  logic [RESULT_WIDTH-1:0] prod;
  logic                    push;
  logic                    pop;
  logic                    res_vld;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts both in-flight products and queued results
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + (CW+1)'(vld_q[i]);
    end
    used      = inflight + (CW+1)'(cnt_q);
    can_issue = aclr_n && (used < (CW+1)'(DEPTH));
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (can_issue && !gnt_vld && bus.req_valid[i] &&
            ((int'(rr_ptr_q) + k) % NUM_REQ == i)) begin
          gnt_vld = 1'b1;
          gnt_id  = ID_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                    : gnt_id + 1'b1;
    end
  end

  always_comb begin
    ax_sel = '0;
    ay_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_WIDTH'(i)) begin
        ax_sel = bus.req_ax[i*AX_WIDTH +: AX_WIDTH];
        ay_sel = bus.req_ay[i*AY_WIDTH +: AY_WIDTH];
      end
    end
  end

  assign bus.req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;

  dsp_27x27s #(
    .FAMILY      (FAMILY),
    .LATENCY     (LATENCY),
    .AX_WIDTH    (AX_WIDTH),
    .AY_WIDTH    (AY_WIDTH),
    .RESULT_WIDTH(RESULT_WIDTH)
  ) u_mul (
    .clk     (clk),
    .ax_i    (ax_sel),
    .ay_i    (ay_sel),
    .result_o(prod)
  );

  assign push    = vld_q[LATENCY-1];
  assign res_vld = (cnt_q != '0);
  assign pop     = res_vld && bus.res_ready;

  always_comb begin
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      vld_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        vid_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= gnt_vld;
      vid_q[0] <= gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        vid_q[i] <= vid_q[i-1];
      end
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {vid_q[LATENCY-1], prod};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  assign bus.res_valid = res_vld;
  assign {bus.res_id, bus.res_data} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (aclr_n) begin
      assert (!(push && !pop && cnt_q == CW'(DEPTH)));
      assert ($onehot0(bus.req_ready));
    end
  end
endmodule

// File: tb/tb_dsp_27x27s_arbiter.sv
// Directed bench for dsp_27x27s_arbiter: arbitration order, credit,
// backpressure, corner products and mid-operation reset.
module tb_dsp_27x27s_arbiter;
  localparam int N   = 4;
  localparam int AXW = 27;
  localparam int AYW = 27;
  localparam int RW  = 54;
  localparam int IDW = 2;
  localparam int LAT = 3;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [RW-1:0]  p;
  } exp_t;

  logic clk = 1'b0;
  logic aclr_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb [$];
  logic [RW-1:0] cexp [4];

  always #5 clk = ~clk;

  dsp_27x27s_arbiter_if #(
    .NUM_REQ(N), .AX_WIDTH(AXW), .AY_WIDTH(AYW),
    .RESULT_WIDTH(RW), .ID_WIDTH(IDW)
  ) bus ();

  dsp_27x27s_arbiter #(
    .FAMILY("Agilex"), .LATENCY(LAT), .NUM_REQ(N),
    .AX_WIDTH(AXW), .AY_WIDTH(AYW),
    .RESULT_WIDTH(RW), .ID_WIDTH(IDW)
  ) dut (
    .clk   (clk),
    .aclr_n(aclr_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mref(input logic [AXW-1:0] a,
                                         input logic [AYW-1:0] b);
    longint sa;
    longint sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    return RW'(sa * sb_);
  endfunction

  task automatic set_op(input int i, input logic [AXW-1:0] a,
                        input logic [AYW-1:0] b);
    bus.req_ax[i*AXW +: AXW] = a;
    bus.req_ay[i*AYW +: AYW] = b;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted request must come back once, in order
  always @(negedge clk) begin
    exp_t e;
    if (!aclr_n) begin
      sb.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          chk("res_unexpected", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_res_id", 64'(bus.res_id), 64'(e.id));
          chk("sb_res_data", 64'(bus.res_data), 64'(e.p));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.id = IDW'(i);
          e.p  = mref(bus.req_ax[i*AXW +: AXW], bus.req_ay[i*AYW +: AYW]);
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    cexp[0] = 54'd1;
    cexp[1] = 54'h10_0000_0000_0000;
    cexp[2] = 54'h30_0000_0400_0000;
    cexp[3] = 54'd0;
    bus.req_valid = 4'hF;
    bus.req_ax    = '0;
    bus.req_ay    = '0;
    bus.res_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_res_id", 64'(bus.res_id), 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    nxt();
    bus.req_valid = '0;
    aclr_n        = 1'b1;
    bus.res_ready = 1'b1;

    // single requester, streaming
    for (int k = 0; k < 30; k++) begin
      nxt();
      if (k < 20) begin
        bus.req_valid = 4'b0001;
        set_op(0, AXW'($urandom), AYW'($urandom));
      end else begin
        bus.req_valid = '0;
      end
      @(negedge clk);
      chk("t1_ready", 64'(bus.req_ready), (k < 20) ? 64'd1 : 64'd0);
      chk("t1_res_valid", 64'(bus.res_valid),
          (k >= LAT + 1 && k < 20 + LAT + 1) ? 64'd1 : 64'd0);
    end
    chk("t1_drained", 64'(sb.size()), 64'd0);

    // reset pointer, then all four with corner operands
    nxt();
    aclr_n = 1'b0;
    @(negedge clk);
    chk("rst2_res_valid", 64'(bus.res_valid), 64'd0);
    nxt();
    aclr_n = 1'b1;
    set_op(0, 27'h7FF_FFFF, 27'h7FF_FFFF);
    set_op(1, 27'h400_0000, 27'h400_0000);
    set_op(2, 27'h3FF_FFFF, 27'h400_0000);
    set_op(3, 27'd0, 27'd12345);
    for (int k = 0; k < 18; k++) begin
      nxt();
      bus.req_valid = (k < 12) ? 4'hF : 4'h0;
      @(negedge clk);
      chk("t2_ready", 64'(bus.req_ready),
          (k < 12) ? (64'd1 << (k % 4)) : 64'd0);
      if (k >= 4 && k < 16) begin
        chk("t2_res_id", 64'(bus.res_id), 64'((k - 4) % 4));
        chk("t2_res_data", 64'(bus.res_data), 64'(cexp[(k - 4) % 4]));
      end
    end
    chk("t2_drained", 64'(sb.size()), 64'd0);

    // backpressure: exactly DEPTH transfers, then recovery
    for (int k = 0; k < 21; k++) begin
      logic [3:0] er;
      nxt();
      if (k == 0) begin
        bus.req_valid = 4'hF;
        bus.res_ready = 1'b0;
      end
      if (k == 10) bus.res_ready = 1'b1;
      if (k == 14) bus.req_valid = 4'h0;
      @(negedge clk);
      case (k)
        0, 4:    er = 4'b0001;
        1, 11:   er = 4'b0010;
        2, 12:   er = 4'b0100;
        3, 13:   er = 4'b1000;
        default: er = 4'b0000;
      endcase
      chk("t4_ready", 64'(bus.req_ready), 64'(er));
      chk("t4_res_valid", 64'(bus.res_valid),
          (k >= 4 && k < 18) ? 64'd1 : 64'd0);
      if (k >= 4 && k < 10) chk("t4_hold_id", 64'(bus.res_id), 64'd0);
      if (k >= 10 && k < 18) begin
        chk("t4_res_id", 64'(bus.res_id), 64'((k - 10) % 4));
      end
    end
    chk("t4_drained", 64'(sb.size()), 64'd0);

    // round-robin wrap from pointer 3
    nxt();
    bus.req_valid = 4'b0100;
    set_op(2, AXW'($urandom), AYW'($urandom));
    @(negedge clk);
    chk("t5_r2_first", 64'(bus.req_ready), 64'b0100);
    nxt();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("t5_r2_ptr3", 64'(bus.req_ready), 64'b0100);
    nxt();
    bus.req_valid = 4'b0110;
    @(negedge clk);
    chk("t5_r1_wrap", 64'(bus.req_ready), 64'b0010);
    nxt();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("t5_r2_after", 64'(bus.req_ready), 64'b0100);
    nxt();
    bus.req_valid = 4'b0000;
    repeat (8) nxt();
    @(negedge clk);
    chk("t5_drained", 64'(sb.size()), 64'd0);

    // reset with three products in flight
    for (int k = 0; k < 3; k++) begin
      nxt();
      bus.req_valid = 4'b0001;
      set_op(0, 27'd100 + AXW'(k), 27'd200);
      @(negedge clk);
      chk("t6_issue", 64'(bus.req_ready), 64'b0001);
    end
    nxt();
    aclr_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("t6_rst_ready", 64'(bus.req_ready), 64'd0);
    nxt();
    bus.req_valid = '0;
    aclr_n        = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6_no_stale", 64'(bus.res_valid), 64'd0);
      nxt();
    end
    bus.req_valid = 4'b0010;
    set_op(1, 27'd3, 27'h7FF_FFFB);
    @(negedge clk);
    chk("t6_new_issue", 64'(bus.req_ready), 64'b0010);
    for (int j = 1; j < 6; j++) begin
      nxt();
      bus.req_valid = '0;
      @(negedge clk);
      chk("t6_res_valid", 64'(bus.res_valid),
          (j == LAT + 1) ? 64'd1 : 64'd0);
      if (j == LAT + 1) begin
        chk("t6_res_id", 64'(bus.res_id), 64'd1);
        chk("t6_res_data", 64'(bus.res_data), 64'h3F_FFFF_FFFF_FFF1);
      end
    end
    chk("t6_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
